// File: rtl/multi_core_run_ctrl_if.sv
// Host/core-array side signals of the multi-core run controller, bundled so the
// controller and its environment share one declaration.
interface multi_core_run_ctrl_if #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 12,
  parameter int N_REGS  = 16,
  parameter int CNT_W   = 24
);
  localparam int RC_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int RR_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic                             start;
  logic [CNT_W-1:0]                 timeout_limit;
  logic [N_CORES-1:0]               start_process;
  logic [N_CORES-1:0]               end_process;
  logic [N_CORES*N_REGS*DATA_W-1:0] core_regs;
  logic [RC_W-1:0]                  rd_core;
  logic [RR_W-1:0]                  rd_reg;
  logic [DATA_W-1:0]                rd_data;
  logic                             busy;
  logic                             done;
  logic                             timed_out;
  logic [N_CORES-1:0]               done_mask;
  logic [CNT_W-1:0]                 cycle_count;

  modport master (
    output start, timeout_limit, end_process, core_regs, rd_core, rd_reg,
    input  start_process, rd_data, busy, done, timed_out, done_mask, cycle_count
  );

  modport slave (
    input  start, timeout_limit, end_process, core_regs, rd_core, rd_reg,
    output start_process, rd_data, busy, done, timed_out, done_mask, cycle_count
  );
endinterface

// File: rtl/multi_core_run_ctrl.sv
// Launches N cores together, waits for all completions or a timeout, settles,
// then snapshots every core's register outputs for addressed readback.
module multi_core_run_ctrl #(
  parameter int N_CORES       = 4,
  parameter int DATA_W        = 12,
  parameter int N_REGS        = 16,
  parameter int CNT_W         = 24,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_core_run_ctrl_if.slave  bus
);
  localparam int RC_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int RR_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SET_W-1:0] SETTLE_LAST =
    SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [RC_W:0] CORE_LIMIT = (RC_W+1)'(N_CORES);
  localparam logic [RR_W:0] REG_LIMIT  = (RR_W+1)'(N_REGS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // A zero settle interval skips SETTLE entirely.
  localparam logic [2:0] S_AFTER_RUN = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;

  logic [2:0]         state;
  logic [SET_W-1:0]   settle_cnt;
  logic [N_CORES-1:0] done_mask;
  logic [CNT_W-1:0]   cycle_count;
  logic               timed_out;
  logic [DATA_W-1:0]  snap [N_CORES][N_REGS];

  logic [N_CORES-1:0] seen_mask;
  logic               all_done;
  logic [CNT_W:0]     cnt_plus1;
  logic               timeout_hit;

  assign seen_mask   = done_mask | bus.end_process;
  assign all_done    = &seen_mask;
  assign cnt_plus1   = {1'b0, cycle_count} + (CNT_W+1)'(1);
  assign timeout_hit = (bus.timeout_limit != '0) && (cnt_plus1 >= {1'b0, bus.timeout_limit});

  // NOTE: the snapshot array is reset along with the control state because a
  // readback after reset must return zero, not whatever the flops powered up to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      done_mask   <= '0;
      cycle_count <= '0;
      timed_out   <= 1'b0;
      for (int c = 0; c < N_CORES; c++)
        for (int r = 0; r < N_REGS; r++)
          snap[c][r] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state       <= S_LAUNCH;
            done_mask   <= '0;
            cycle_count <= '0;
            timed_out   <= 1'b0;
          end
        end
        S_LAUNCH: state <= S_RUN;
        S_RUN: begin
          done_mask <= seen_mask;
          if (~&cycle_count) cycle_count <= cycle_count + CNT_W'(1);
          // Completion takes priority over a timeout landing on the same cycle.
          if (all_done) begin
            state      <= S_AFTER_RUN;
            settle_cnt <= '0;
          end else if (timeout_hit) begin
            timed_out  <= 1'b1;
            state      <= S_AFTER_RUN;
            settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          done_mask <= seen_mask;
          if (settle_cnt == SETTLE_LAST) state <= S_CAPTURE;
          else settle_cnt <= settle_cnt + SET_W'(1);
        end
        S_CAPTURE: begin
          for (int c = 0; c < N_CORES; c++)
            for (int r = 0; r < N_REGS; r++)
              snap[c][r] <= bus.core_regs[(c*N_REGS + r)*DATA_W +: DATA_W];
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic running;
  assign running = (state == S_RUN) || (state == S_SETTLE) || (state == S_CAPTURE);

  assign bus.start_process = running ? '1 : '0;
  assign bus.busy          = running || (state == S_LAUNCH);
  assign bus.done          = (state == S_DONE);
  assign bus.timed_out     = timed_out;
  assign bus.done_mask     = done_mask;
  assign bus.cycle_count   = cycle_count;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    bus.rd_data = '0;
    if (({1'b0, bus.rd_core} < CORE_LIMIT) && ({1'b0, bus.rd_reg} < REG_LIMIT))
      bus.rd_data = snap[bus.rd_core][bus.rd_reg];
  end
endmodule
